// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and helpers for the pipe_chain slice:
//               default payload width/depth and the occupancy counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_DEFAULT_DEPTH = 4;

    // Occupancy spans 0..DEPTH+1 (all stages plus the optional skid entry).
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid
// Description : One-entry skid register. Passes data straight through while
//               empty; parks the item when downstream stalls. Upstream ready
//               depends only on the registered full flag and the clear input.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_park;

    assign o_ready = ~r_valid & ~i_clear;
    assign o_valid = (r_valid | i_valid) & ~i_clear;
    assign o_data  = r_valid ? r_data : i_data;
    assign o_full  = r_valid;

    // An offered item that cannot pass through this cycle is parked.
    assign w_park  = ~r_valid & i_valid & ~i_ready & ~i_clear;

    // Full flag: set on park, cleared once the parked item is taken.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            if (i_ready) begin
                r_valid <= 1'b0;
            end
        end else if (w_park) begin
            r_valid <= 1'b1;
        end
    end

    // Payload register loads only when an item is parked.
    always_ff @(posedge clk) begin
        if (w_park) begin
            r_data <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_chain
// Description : DEPTH-stage valid/ready register pipeline with bubble
//               collapsing, per-stage flush, global flush and occupancy count.
//               Optional output skid entry enabled by PIPE_CHAIN_SKID_BUF_EN,
//               which removes the combinational out_ready -> in_ready path.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic [DEPTH-1:0]            flush_mask,
    input  logic                        flush_all,
    output logic [occ_width(DEPTH)-1:0] occ
);

    localparam int c_OCC_W = occ_width(DEPTH);
    localparam int c_LAST  = DEPTH - 1;

    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data     [DEPTH];
    logic [WIDTH-1:0]   w_stage_in [DEPTH];
    logic [DEPTH-1:0]   w_offer;
    logic [DEPTH-1:0]   w_emit;
    logic [DEPTH-1:0]   w_cap;
    logic [DEPTH-1:0]   w_load;
    logic               w_kill;
    logic               w_last_rdy;
    logic               w_skid_full;
    logic [c_OCC_W-1:0] w_count;

    // Reset behaves like a global flush for the handshake outputs.
    assign w_kill  = rst | flush_all;

    // A stage offers its item onward only if valid and not being flushed.
    assign w_offer = r_valid & ~flush_mask & {DEPTH{~w_kill}};

    // Ready chain, walked from the output back to stage 0.
    always_comb begin
        logic w_down;
        w_down = w_last_rdy;
        w_emit = '0;
        w_cap  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_emit[i] = w_offer[i] & w_down;
            w_cap[i]  = (~r_valid[i] | w_emit[i]) & ~flush_mask[i] & ~w_kill;
            w_down    = w_cap[i];
        end
    end

    assign in_ready = w_cap[0];

    // A stage loads when its upstream neighbour actually hands over an item.
    always_comb begin
        w_load    = '0;
        w_load[0] = in_valid & w_cap[0];
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_emit[i - 1];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_in
            if (gi == 0) begin : g_head
                assign w_stage_in[gi] = in_data;
            end else begin : g_body
                assign w_stage_in[gi] = r_data[gi - 1];
            end
        end
    endgenerate

    // Stage valid bits: flush wins over load, load wins over release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_all || flush_mask[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (w_emit[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload registers load only on capture; bubbles never overwrite data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_load[i]) begin
                r_data[i] <= w_stage_in[i];
            end
        end
    end

`ifdef PIPE_CHAIN_SKID_BUF_EN
    pipe_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_kill),
        .i_valid (w_offer[c_LAST]),
        .o_ready (w_last_rdy),
        .i_data  (r_data[c_LAST]),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_full  (w_skid_full)
    );
`else
    assign w_last_rdy  = out_ready;
    assign out_valid   = w_offer[c_LAST];
    assign out_data    = r_data[c_LAST];
    assign w_skid_full = 1'b0;
`endif

    // Occupancy is the population count of held entries.
    always_comb begin
        w_count = c_OCC_W'(w_skid_full);
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + c_OCC_W'(r_valid[i]);
        end
    end

    assign occ = rst ? '0 : w_count;

endmodule
`default_nettype wire
